// File: rtl/sort8_stream_adapter.sv
// Stream adapter around the 8-input iterative sorter: gathers an 8-word frame, pulses a load,
// waits SORT_CYCLES recirculation cycles, then streams the captured results out, b00 first.
module sort8_stream_adapter #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SORT_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic [WIDTH-1:0] a0,
   output logic [WIDTH-1:0] a1,
   output logic [WIDTH-1:0] a2,
   output logic [WIDTH-1:0] a3,
   output logic [WIDTH-1:0] a4,
   output logic [WIDTH-1:0] a5,
   output logic [WIDTH-1:0] a6,
   output logic [WIDTH-1:0] a7,
   output logic             select,
   input  logic [WIDTH-1:0] b00,
   input  logic [WIDTH-1:0] b11,
   input  logic [WIDTH-1:0] b22,
   input  logic [WIDTH-1:0] b33,
   input  logic [WIDTH-1:0] b44,
   input  logic [WIDTH-1:0] b55,
   input  logic [WIDTH-1:0] b66,
   input  logic [WIDTH-1:0] b77,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   input  logic             m_ready,
   output logic             busy
);

   localparam int unsigned CNT_W = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

   typedef enum logic [1:0] {StFill, StLoad, StSort, StDrain} state_e;

   state_e           state_q, state_d;
   logic [2:0]       wr_idx_q, wr_idx_d;
   logic [2:0]       rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q [8];
   logic [WIDTH-1:0] r_q [8];
   logic [WIDTH-1:0] b_vec [8];
   logic             s_accept;
   logic             m_accept;
   logic             capture;

   assign b_vec[0] = b00;
   assign b_vec[1] = b11;
   assign b_vec[2] = b22;
   assign b_vec[3] = b33;
   assign b_vec[4] = b44;
   assign b_vec[5] = b55;
   assign b_vec[6] = b66;
   assign b_vec[7] = b77;

   // Handshakes only steer next-state logic; every output decodes registered state.
   assign s_accept = (state_q == StFill) && s_valid;
   assign m_accept = (state_q == StDrain) && m_ready;

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      unique case (state_q)
         StFill: begin
            if (s_accept) begin
               wr_idx_d = wr_idx_q + 3'd1;
               if (wr_idx_q == 3'd7) state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = CNT_W'(SORT_CYCLES - 1);
            state_d = StSort;
         end
         StSort: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StDrain: begin
            if (m_accept) begin
               rd_idx_d = rd_idx_q + 3'd1;
               if (rd_idx_q == 3'd7) state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StFill;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            a_q[i] <= '0;
            r_q[i] <= '0;
         end
      end else begin
         if (s_accept) a_q[wr_idx_q] <= s_data;
         if (capture) begin
            for (int i = 0; i < 8; i++) r_q[i] <= b_vec[i];
         end
      end
   end

   assign s_ready = (state_q == StFill);
   assign select  = (state_q == StLoad);
   assign m_valid = (state_q == StDrain);
   assign m_data  = m_valid ? r_q[rd_idx_q] : '0;
   assign m_last  = m_valid && (rd_idx_q == 3'd7);
   assign busy    = (state_q != StFill) || (wr_idx_q != 3'd0);

   assign a0 = a_q[0];
   assign a1 = a_q[1];
   assign a2 = a_q[2];
   assign a3 = a_q[3];
   assign a4 = a_q[4];
   assign a5 = a_q[5];
   assign a6 = a_q[6];
   assign a7 = a_q[7];

endmodule

// File: tb/tb_sort8_stream_adapter.sv
// Bench for sort8_stream_adapter: two instances (SORT_CYCLES 8 and 1) each paired with a
// behavioural ascending sorter; directed frame table plus reset and flow-control sequences.
module tb_sort8_stream_adapter;

   typedef logic [0:7][31:0] frame_t;
   typedef struct packed {
      logic   bubble;
      frame_t din;
      frame_t dout;
   } vec_t;

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        s_valid = 1'b0;
   logic        m_ready = 1'b1;
   logic [31:0] s_data  = '0;
   logic        dut_sel = 1'b0;

   wire              s_ready1, select1, m_valid1, m_last1, busy1;
   wire              s_ready2, select2, m_valid2, m_last2, busy2;
   wire [31:0]       m_data1, m_data2;
   wire [0:7][31:0]  a1p, a2p;
   frame_t           b1p = '0;
   frame_t           b2p = '0;

   int errors = 0;
   int checks = 0;
   int dead_n = 0;
   vec_t vecs [4];

   always #5 clk = ~clk;

   sort8_stream_adapter #(.WIDTH(32), .SORT_CYCLES(8)) dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
      .a0(a1p[0]), .a1(a1p[1]), .a2(a1p[2]), .a3(a1p[3]),
      .a4(a1p[4]), .a5(a1p[5]), .a6(a1p[6]), .a7(a1p[7]), .select(select1),
      .b00(b1p[0]), .b11(b1p[1]), .b22(b1p[2]), .b33(b1p[3]),
      .b44(b1p[4]), .b55(b1p[5]), .b66(b1p[6]), .b77(b1p[7]),
      .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1), .m_ready(m_ready), .busy(busy1)
   );

   sort8_stream_adapter #(.WIDTH(32), .SORT_CYCLES(1)) dut2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
      .a0(a2p[0]), .a1(a2p[1]), .a2(a2p[2]), .a3(a2p[3]),
      .a4(a2p[4]), .a5(a2p[5]), .a6(a2p[6]), .a7(a2p[7]), .select(select2),
      .b00(b2p[0]), .b11(b2p[1]), .b22(b2p[2]), .b33(b2p[3]),
      .b44(b2p[4]), .b55(b2p[5]), .b66(b2p[6]), .b77(b2p[7]),
      .m_valid(m_valid2), .m_data(m_data2), .m_last(m_last2), .m_ready(m_ready), .busy(busy2)
   );

   function automatic frame_t sort8(input frame_t v);
      frame_t      t;
      logic [31:0] x;
      t = v;
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 7 - i; j++) begin
            if (t[j] > t[j+1]) begin
               x = t[j];
               t[j] = t[j+1];
               t[j+1] = x;
            end
         end
      end
      return t;
   endfunction

   always @(posedge clk) if (select1) b1p <= sort8(a1p);
   always @(posedge clk) if (select2) b2p <= sort8(a2p);

   wire             cur_s_ready = dut_sel ? s_ready2 : s_ready1;
   wire             cur_select  = dut_sel ? select2  : select1;
   wire             cur_m_valid = dut_sel ? m_valid2 : m_valid1;
   wire             cur_m_last  = dut_sel ? m_last2  : m_last1;
   wire             cur_busy    = dut_sel ? busy2    : busy1;
   wire [31:0]      cur_m_data  = dut_sel ? m_data2  : m_data1;
   wire [0:7][31:0] cur_a       = dut_sel ? a2p      : a1p;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle; while an upstream word is held outside FILL, it must be ignored.
   task automatic tick(input logic hold, input frame_t din);
      @(negedge clk);
      if (hold) begin
         check("hold_s_ready", 32'(cur_s_ready), 32'd0);
         check("hold_a", 32'(cur_a === din), 32'd1);
         s_data = 32'hDEAD0000 + 32'(dead_n);
         dead_n++;
      end
   endtask

   task automatic run_frame(input vec_t v, input logic hold, input int abort);
      int   i   = 0;
      int   cyc = 0;
      int   k;
      int   lat = dut_sel ? 3 : 10;
      logic tog = 1'b0;
      check("idle_busy", 32'(cur_busy), 32'd0);
      while (i < 8 && cyc < 100) begin
         tog = ~tog;
         if (v.bubble && !tog) s_valid = 1'b0;
         else begin
            s_valid = 1'b1;
            s_data  = v.din[i];
         end
         if (s_valid && cur_s_ready) i++;
         @(negedge clk);
         cyc++;
      end
      if (i < 8) begin
         check("accept_timeout", 32'(i), 32'd8);
         return;
      end
      if (hold) begin
         s_data = 32'hDEAD0000 + 32'(dead_n);
         dead_n++;
      end else s_valid = 1'b0;
      check("select_on", 32'(cur_select), 32'd1);
      check("busy_on", 32'(cur_busy), 32'd1);
      check("a_loaded", 32'(cur_a === v.din), 32'd1);
      tick(hold, v.din);
      k = 2;
      check("select_off", 32'(cur_select), 32'd0);
      while (!cur_m_valid && k < 60) begin
         tick(hold, v.din);
         k++;
      end
      check("latency", 32'(k), 32'(lat));
      if (!cur_m_valid) return;
      for (int b = 0; b < 8; b++) begin
         if (b == abort) begin
            #2 rst = 1'b0;
            #1;
            check("rst_m_valid", 32'(cur_m_valid), 32'd0);
            check("rst_m_data", cur_m_data, 32'd0);
            check("rst_m_last", 32'(cur_m_last), 32'd0);
            check("rst_select", 32'(cur_select), 32'd0);
            check("rst_busy", 32'(cur_busy), 32'd0);
            check("rst_a", 32'(cur_a === '0), 32'd1);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         check("beat_valid", 32'(cur_m_valid), 32'd1);
         check("beat_data", cur_m_data, v.dout[b]);
         check("beat_last", 32'(cur_m_last), 32'(b == 7));
         check("beat_busy", 32'(cur_busy), 32'd1);
         if (v.bubble && b == 4) begin
            m_ready = 1'b0;
            repeat (3) begin
               tick(hold, v.din);
               check("stall_data", cur_m_data, v.dout[4]);
               check("stall_valid", 32'(cur_m_valid), 32'd1);
            end
            m_ready = 1'b1;
         end
         if (b < 7) tick(hold, v.din);
         else @(negedge clk);
      end
      check("end_valid", 32'(cur_m_valid), 32'd0);
      check("end_busy", 32'(cur_busy), 32'd0);
      check("end_s_ready", 32'(cur_s_ready), 32'd1);
      if (hold) check("no_accept_on_last", 32'(cur_a === v.din), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0].bubble = 1'b0;
      vecs[0].din  = {32'd11, 32'd90, 32'd43, 32'd70, 32'd30, 32'd44, 32'd40, 32'd32};
      vecs[0].dout = {32'd11, 32'd30, 32'd32, 32'd40, 32'd43, 32'd44, 32'd70, 32'd90};
      vecs[1] = vecs[0];
      vecs[1].bubble = 1'b1;
      vecs[2].bubble = 1'b0;
      vecs[2].din  = {32'hFFFFFFFF, 32'd0, 32'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd5};
      vecs[2].dout = {32'd0, 32'd0, 32'd5, 32'd5, 32'd5, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3].bubble = 1'b0;
      vecs[3].din  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      vecs[3].dout = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_select", 32'(cur_select), 32'd0);
      check("reset_m_valid", 32'(cur_m_valid), 32'd0);
      check("reset_m_data", cur_m_data, 32'd0);
      check("reset_m_last", 32'(cur_m_last), 32'd0);
      check("reset_busy", 32'(cur_busy), 32'd0);
      check("reset_a", 32'(cur_a === '0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("reset_s_ready", 32'(cur_s_ready), 32'd1);

      // Basic, bubbles/backpressure, extremes
      for (int n = 0; n < 3; n++) run_frame(vecs[n], 1'b0, 8);

      // Upstream holds valid through LOAD/SORT/DRAIN; first accept only after m_last
      run_frame(vecs[0], 1'b1, 8);
      s_data = 32'hDEAD0100;
      @(negedge clk);
      check("post_last_accept", cur_a[0], 32'hDEAD0100);
      check("post_last_busy", 32'(cur_busy), 32'd1);
      s_valid = 1'b0;

      // Reset with a partial frame in FILL, then mid-DRAIN after 3 beats
      rst = 1'b0;
      @(negedge clk);
      check("fill_rst_busy", 32'(cur_busy), 32'd0);
      check("fill_rst_a", 32'(cur_a === '0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      run_frame(vecs[0], 1'b0, 3);
      run_frame(vecs[3], 1'b0, 8);

      // Back-to-back frames on the SORT_CYCLES=1 instance
      dut_sel = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_frame(vecs[0], 1'b0, 8);
      run_frame(vecs[2], 1'b0, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sort8_stream_adapter.md
Name: sort8_stream_adapter

Overview:
- Streaming front/back end for the 8-input iterative sorter (`sorting_8`).
- Collects eight 32-bit words from a valid/ready input stream and drives them onto the sorter's a0..a7 with a one-cycle select load pulse.
- Waits a fixed number of recirculation cycles, captures b00..b77 and emits them as an 8-beat valid/ready output stream, b00 first.
- Turns the sorter's parallel, select-driven interface into a frame-based stream for upstream/downstream blocks.

Parameters:
- WIDTH, 32: data word width; matches sorter ports.
- SORT_CYCLES, 8: clock cycles with select=0 after the load pulse before b00..b77 are captured; legal range >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_data  in  WIDTH  input word.
- s_ready  out  1  adapter accepts input word.
- a0..a7  out  WIDTH each  operands to sorter; a0 = first word of frame.
- select  out  1  sorter load strobe; 1 = load a0..a7, 0 = recirculate.
- b00..b77  in  WIDTH each  sorter outputs.
- m_valid  out  1  output word valid.
- m_data  out  WIDTH  output word.
- m_last  out  1  marks 8th output word of frame.
- m_ready  in  1  downstream accepts output word.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to FILL; all counters 0.
  - a0..a7=0, select=0, m_valid=0, m_data=0, m_last=0, busy=0; result buffer cleared.
  - s_ready=1 from the first cycle after rst deasserts.
- FSM states: FILL -> LOAD -> SORT -> DRAIN -> FILL. Only one frame is in flight; input and output phases do not overlap.
- FILL:
  - s_ready=1; an accept is s_valid && s_ready at a rising edge.
  - Accepted word is written to a[wr_idx]; wr_idx increments 0..7.
  - The accept with wr_idx=7 moves the FSM to LOAD; wr_idx wraps to 0.
  - a0..a7 hold their value at all other times.
- LOAD: exactly one cycle; select=1, s_ready=0. Next state SORT, sort counter loaded with SORT_CYCLES-1.
- SORT:
  - select=0, s_ready=0; counter decrements each cycle.
  - In the cycle counter==0: the edge captures b00..b77 into result buffer r0..r7 and the FSM moves to DRAIN.
  - SORT lasts exactly SORT_CYCLES cycles.
- DRAIN:
  - m_valid=1, m_data=r[rd_idx], m_last=(rd_idx==7); s_ready=0.
  - A beat transfers on m_valid && m_ready; rd_idx increments.
  - m_data and m_last hold stable while m_ready=0.
  - The transfer with rd_idx=7 returns the FSM to FILL; m_valid drops the next cycle, rd_idx returns to 0.
- Latency: 8th input accept at edge E.
  - select=1 in the cycle after E.
  - First m_valid=1 in cycle E+2+SORT_CYCLES (counting the cycle after E as E+1).
- All outputs are registered or decoded from registered state. There are no combinational paths from s_valid or m_ready to any output.
- busy = (state!=FILL) || (wr_idx!=0).
- s_valid while s_ready=0: ignored, not buffered; the upstream must hold the word.
- Same-cycle m_last transfer and s_valid=1: this s_valid is not accepted. The first accept of the next frame is at the following edge.
- Reset mid-frame (any state): partial input and undrained results are discarded, with no partial output beat. The next frame starts at wr_idx=0.
- Words are treated as unsigned opaque data. Sort order is whatever the sorter produces; the adapter never reorders b00..b77.

Test Plan:
- Basic frame, SORT_CYCLES=8, m_ready=1, inputs 11,90,43,70,30,44,40,32 back-to-back, real sorter:
  - select high for exactly 1 cycle, in the cycle after the 8th accept.
  - Output stream is 11,30,32,40,43,44,70,90 on consecutive cycles, m_last only on 90.
  - First m_valid at E+10.
- Input bubbles and output backpressure: s_valid toggles 1/0 and m_ready is 0 for 3 cycles on beat 4.
  - Same sorted sequence is produced.
  - m_data stays constant during the stall; no beat is duplicated or dropped.
- Flow control outside FILL: s_valid held 1 with data 0xDEAD0000+n through LOAD/SORT/DRAIN.
  - s_ready=0 and a0..a7 are unchanged during those states.
  - The next accept occurs only in the cycle after the m_last transfer.
- Reset mid-DRAIN after 3 beats transferred: assert rst low asynchronously between edges.
  - All outputs read 0 immediately.
  - A new frame 8,7,6,5,4,3,2,1 then streams 1..8 with no leftover data.
- Extremes and duplicates: frame 0xFFFFFFFF,0,5,5,0,0xFFFFFFFF,7,5 -> stream 0,0,5,5,5,7,0xFFFFFFFF,0xFFFFFFFF.
- Back-to-back frames with SORT_CYCLES=1:
  - Two frames run with no idle cycles beyond those the FSM requires.
  - busy=1 from the first accept until the last m_last transfer of each frame.
  - busy=0 in cycles spent in FILL with wr_idx=0.
